// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: measurement sequencer for the frequency counter datapath.
// It clears the external edge counter and opens a gate window of a programmed
// length. After a settle delay it presents the count as a one-cycle-valid
// result. Auto-ranging across four gate lengths is optional.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for run, gate closed
//   S_CLEAR  | one-cycle counter clear, range chosen, gate timer loaded
//   S_GATE   | counter enabled for GATE[range] cycles
//   S_SETTLE | gate closed, counter allowed to settle for SETTLE cycles
//   S_LATCH  | result_valid strobe, auto-range decision, loop or stop

module freq_gate_ctrl #(
  parameter int              CNT_W     = 32,
  parameter int              GATE0     = 50_000_000,
  parameter int              GATE1     = 5_000_000,
  parameter int              GATE2     = 500_000,
  parameter int              GATE3     = 50_000,
  parameter int              SETTLE    = 4,
  parameter logic [CNT_W-1:0] HI_THRESH = CNT_W'(99_999_999),
  parameter logic [CNT_W-1:0] LO_THRESH = CNT_W'(9_999)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic             auto_range,
  input  logic [1:0]       range_sel,
  input  logic [CNT_W-1:0] cnt_value,
  input  logic             cnt_ovf,
  output logic             cnt_clear,
  output logic             gate,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic [1:0]       result_range,
  output logic             overrange,
  output logic             result_valid
);

  // One shared down-counter serves both the gate and the settle interval,
  // so it is sized for the longest of them.
  localparam int GMAX_01 = (GATE0 > GATE1) ? GATE0 : GATE1;
  localparam int GMAX_23 = (GATE2 > GATE3) ? GATE2 : GATE3;
  localparam int GMAX_G  = (GMAX_01 > GMAX_23) ? GMAX_01 : GMAX_23;
  localparam int GMAX    = (GMAX_G > SETTLE) ? GMAX_G : SETTLE;
  localparam int TMR_W   = (GMAX > 1) ? $clog2(GMAX) : 1;

  localparam logic [TMR_W-1:0] G0_M1     = TMR_W'(GATE0 - 1);
  localparam logic [TMR_W-1:0] G1_M1     = TMR_W'(GATE1 - 1);
  localparam logic [TMR_W-1:0] G2_M1     = TMR_W'(GATE2 - 1);
  localparam logic [TMR_W-1:0] G3_M1     = TMR_W'(GATE3 - 1);
  localparam logic [TMR_W-1:0] SETTLE_M1 = TMR_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_LATCH  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [1:0]       range, range_nxt;
  logic [1:0]       range_use;
  logic             load_result;
  logic             go_up, go_down;

  function automatic logic [TMR_W-1:0] gate_load(input logic [1:0] r);
    case (r)
      2'd0:    gate_load = G0_M1;
      2'd1:    gate_load = G1_M1;
      2'd2:    gate_load = G2_M1;
      default: gate_load = G3_M1;
    endcase
  endfunction

  // Auto-range decision on the settled count; overflow always forces a shorter gate.
  always_comb begin
    go_up   = (cnt_ovf || (cnt_value > HI_THRESH)) && (range != 2'd3);
    go_down = !go_up && (cnt_value < LO_THRESH) && !cnt_ovf && (range != 2'd0);
  end

  // State register plus timer, range and result registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      range        <= 2'd0;
      result       <= '0;
      result_range <= 2'd0;
      overrange    <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      range <= range_nxt;
      // The gate is already closed here, so the count seen on the way into
      // LATCH equals the count during LATCH; capturing it one edge early lets
      // the result fields be valid alongside the strobe.
      if (load_result) begin
        result       <= cnt_value;
        result_range <= range;
        overrange    <= cnt_ovf;
      end
    end
  end

  // Next-state, timer/range updates and Moore outputs.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    range_nxt    = range;
    range_use    = range;
    load_result  = 1'b0;
    cnt_clear    = 1'b0;
    gate         = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_clear = 1'b1;
        range_use = auto_range ? range : range_sel;
        range_nxt = range_use;
        timer_nxt = gate_load(range_use);
        state_nxt = S_GATE;
      end
      S_GATE: begin
        gate = 1'b1;
        if (timer == '0) begin
          timer_nxt = SETTLE_M1;
          state_nxt = S_SETTLE;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_SETTLE: begin
        if (timer == '0) begin
          load_result = 1'b1;
          state_nxt   = S_LATCH;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_LATCH: begin
        result_valid = 1'b1;
        if (auto_range) begin
          if (go_up)        range_nxt = range + 2'd1;
          else if (go_down) range_nxt = range - 2'd1;
        end
        state_nxt = run ? S_CLEAR : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: an edge-counter stand-in feeds the DUT, a monitor
// logs strobes, and a range/timing model derived from the gate arithmetic
// predicts every measurement.
module tb_freq_gate_ctrl;

  localparam int CNT_W = 32;
  localparam int G0 = 100, G1 = 50, G2 = 20, G3 = 10;
  localparam int S  = 2;
  localparam int HI = 80, LO = 5;

  logic             clock = 1'b0;
  logic             reset_n, run, auto_range;
  logic [1:0]       range_sel;
  logic [CNT_W-1:0] cnt_value = '0;
  logic             cnt_ovf = 1'b0;
  logic             cnt_clear, gate, busy, overrange, result_valid;
  logic [CNT_W-1:0] result;
  logic [1:0]       result_range;

  int  edge_per = 1;
  bit  force_ovf = 1'b0;
  int  phase = 0;
  int  cyc = 0;
  int  gate_n = 0;
  int  checks = 0, errors = 0;
  int  m_range = 0;

  int               clr_q[$];
  int               v_cyc_q[$];
  logic [CNT_W-1:0] v_res_q[$];
  logic [1:0]       v_rng_q[$];
  logic             v_ovf_q[$];

  freq_gate_ctrl #(
    .CNT_W(CNT_W), .GATE0(G0), .GATE1(G1), .GATE2(G2), .GATE3(G3),
    .SETTLE(S), .HI_THRESH(32'd80), .LO_THRESH(32'd5)
  ) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .auto_range(auto_range),
    .range_sel(range_sel), .cnt_value(cnt_value), .cnt_ovf(cnt_ovf),
    .cnt_clear(cnt_clear), .gate(gate), .busy(busy), .result(result),
    .result_range(result_range), .overrange(overrange),
    .result_valid(result_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // External edge counter: one edge every edge_per gated cycles.
  always @(posedge clock) begin
    if (cnt_clear) begin
      cnt_value <= '0;
      phase     <= 0;
      cnt_ovf   <= 1'b0;
    end else if (gate) begin
      if (phase + 1 >= edge_per) begin
        phase     <= 0;
        cnt_value <= cnt_value + 1'b1;
      end else begin
        phase <= phase + 1;
      end
      if (force_ovf) cnt_ovf <= 1'b1;
    end
  end

  // Event log sampled mid-cycle.
  always @(negedge clock) begin
    if (gate) gate_n <= gate_n + 1;
    if (cnt_clear) clr_q.push_back(cyc);
    if (result_valid) begin
      v_cyc_q.push_back(cyc);
      v_res_q.push_back(result);
      v_rng_q.push_back(result_range);
      v_ovf_q.push_back(overrange);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int glen(input int r);
    case (r)
      0: return G0;
      1: return G1;
      2: return G2;
      default: return G3;
    endcase
  endfunction

  function automatic int next_range(input int r, input int c, input bit o);
    if ((o || c > HI) && r < 3) return r + 1;
    if (c < LO && !o && r > 0) return r - 1;
    return r;
  endfunction

  // Runs n back-to-back measurements and checks them against the model.
  task automatic run_and_check(input int n, input int per, input bit aut, input int rsel,
                               input bit fovf, input int drop_dly, input string tag);
    int vb, cb, gb, e, k, clr, vexp, r, g, cnt, gsum;
    vb = v_cyc_q.size();
    cb = clr_q.size();
    gb = gate_n;
    edge_per   = per;
    auto_range = aut;
    range_sel  = 2'(rsel);
    force_ovf  = fovf;
    run        = 1'b1;
    tick();
    e = cyc;
    k = 0;
    while ((v_cyc_q.size() - vb < n - 1) && k < 3000) begin
      tick();
      k++;
      range_sel = cnt_clear ? 2'(rsel) : 2'($urandom);
    end
    repeat (drop_dly) begin
      tick();
      range_sel = cnt_clear ? 2'(rsel) : 2'($urandom);
    end
    run = 1'b0;
    k = 0;
    while ((busy || (v_cyc_q.size() - vb < n)) && k < 3000) begin
      tick();
      k++;
      range_sel = cnt_clear ? 2'(rsel) : 2'($urandom);
    end
    tick();
    tick();
    force_ovf = 1'b0;
    check({tag, "_nvalid"}, 64'(v_cyc_q.size() - vb), 64'(n));
    check({tag, "_nclear"}, 64'(clr_q.size() - cb), 64'(n));
    clr  = e;
    gsum = 0;
    for (int i = 0; i < n; i++) begin
      r    = aut ? m_range : rsel;
      g    = glen(r);
      cnt  = g / per;
      vexp = clr + g + S + 1;
      if (vb + i < v_cyc_q.size()) begin
        check($sformatf("%s_clr%0d", tag, i), 64'(clr_q[cb + i]), 64'(clr));
        check($sformatf("%s_vcyc%0d", tag, i), 64'(v_cyc_q[vb + i]), 64'(vexp));
        check($sformatf("%s_res%0d", tag, i), 64'(v_res_q[vb + i]), 64'(cnt));
        check($sformatf("%s_rng%0d", tag, i), 64'(v_rng_q[vb + i]), 64'(r));
        check($sformatf("%s_ovf%0d", tag, i), 64'(v_ovf_q[vb + i]), 64'(fovf));
      end
      m_range = aut ? next_range(r, cnt, fovf) : rsel;
      clr  = vexp + 1;
      gsum += g;
    end
    check({tag, "_gatecyc"}, 64'(gate_n - gb), 64'(gsum));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gate"}, 64'(gate), 64'(0));
    check({tag, "_clear"}, 64'(cnt_clear), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_result"}, 64'(result), 64'(0));
    check({tag, "_rrange"}, 64'(result_range), 64'(0));
    check({tag, "_ovr"}, 64'(overrange), 64'(0));
    check({tag, "_valid"}, 64'(result_valid), 64'(0));
  endtask

  initial begin
    int vb;
    reset_n    = 1'b0;
    run        = 1'b0;
    auto_range = 1'b0;
    range_sel  = 2'd0;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    tick();

    // Single shot, manual range 2, one edge per two clocks.
    run_and_check(1, 2, 1'b0, 2, 1'b0, 0, "single");
    // Continuous, manual range 3.
    run_and_check(4, 1, 1'b0, 3, 1'b0, 0, "cont");

    // Reset in the middle of a gate window.
    vb = v_cyc_q.size();
    edge_per   = 1;
    auto_range = 1'b0;
    range_sel  = 2'd1;
    run        = 1'b1;
    tick();
    repeat (5) tick();
    check("midrst_gate_open", 64'(gate), 64'(1));
    reset_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    run = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("midrst_novalid", 64'(v_cyc_q.size() - vb), 64'(0));
    m_range = 0;

    // Auto-range up from range 0.
    run_and_check(3, 1, 1'b1, 0, 1'b0, 0, "auto_up");
    // Auto-range down to range 0 and saturation there.
    run_and_check(1, 40, 1'b0, 3, 1'b0, 0, "pre_down");
    run_and_check(5, 40, 1'b1, 0, 1'b0, 0, "auto_down");
    // Overflow at range 3 stays at range 3.
    run_and_check(1, 1, 1'b0, 3, 1'b1, 0, "ovf_man");
    run_and_check(2, 1, 1'b1, 0, 1'b1, 0, "ovf_auto");
    // run dropped mid-gate: measurement completes, one strobe.
    run_and_check(1, 3, 1'b0, 2, 1'b0, 5, "drop");

    // Randomized measurements.
    for (int t = 0; t < 8; t++) begin
      run_and_check($urandom_range(1, 3), $urandom_range(1, 12), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 0,
                    $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_gate_ctrl.md
# freq_gate_ctrl

Measurement sequencer for the frequency counter datapath. It clears the external edge counter, opens a gate window of a programmed length, waits for the counter to settle, then latches the count as a one-cycle-valid result. It supports single-shot and continuous measurement, and optional auto-ranging across four gate lengths. It sits between the edge counter and the seven-segment display/BCD path.

## Interface
- CNT_W, 32, width of counter value and result
- GATE0, 50_000_000, gate length in clock cycles for range 0 (longest)
- GATE1, 5_000_000, gate length for range 1
- GATE2, 500_000, gate length for range 2
- GATE3, 50_000, gate length for range 3 (shortest); all GATEn ≥ 1
- SETTLE, 4, idle cycles between gate close and latch; ≥ 1
- HI_THRESH, 32'd99_999_999, auto-range up when count > HI_THRESH
- LO_THRESH, 32'd9_999, auto-range down when count < LO_THRESH
- clock  in  1  system clock, all logic rising-edge
- reset_n  in  1  synchronous, active-low reset
- run  in  1  level; 1 = keep measuring, 0 = stop after current measurement
- auto_range  in  1  1 = auto-ranging, 0 = use range_sel
- range_sel  in  2  manual range, sampled in CLEAR
- cnt_value  in  CNT_W  edge count from counter
- cnt_ovf  in  1  counter wrapped during the gate (sticky until cleared)
- cnt_clear  out  1  one-cycle clear to counter
- gate  out  1  count enable to counter
- busy  out  1  high in any state except IDLE
- result  out  CNT_W  latched count
- result_range  out  2  range used for result
- overrange  out  1  cnt_ovf captured with result
- result_valid  out  1  one-cycle strobe, result fields updated

## Operation
- States: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE: gate=0. If run=1, go to CLEAR.
- CLEAR: cnt_clear=1 for this cycle only. In manual mode, range ← range_sel. Gate timer ← GATE[range]−1. Go to GATE.
- GATE: gate=1. Timer decrements each cycle. At timer==0, settle timer ← SETTLE−1 and go to SETTLE. gate is high for exactly GATE[range] cycles.
- SETTLE: gate=0. Timer decrements. At 0, go to LATCH.
- LATCH:
  - result ← cnt_value, result_range ← range, overrange ← cnt_ovf, result_valid=1.
  - Auto-range applies only if auto_range=1, sampled in this cycle:
    - If (cnt_ovf or cnt_value > HI_THRESH) and range<3, then range+1.
    - Else if cnt_value < LO_THRESH and cnt_ovf=0 and range>0, then range−1.
    - Otherwise range holds. It saturates at 0 and 3.
  - The new range takes effect from the next CLEAR.
  - Next state: CLEAR if run=1, else IDLE.
- run falling mid-measurement does not abort. The current measurement completes, LATCH fires, then the block goes to IDLE.
- range_sel changes outside CLEAR are ignored. auto_range toggling takes effect at the next LATCH/CLEAR.
- Gate timer width must hold max(GATEn)−1. Result is the raw count. Downstream scales by range (Hz = count × CLK_HZ / GATE[range]).

## Timing
- Reset (reset_n=0 at an edge): state IDLE, range 0, gate 0, cnt_clear 0, busy 0, result 0, result_range 0, overrange 0, result_valid 0, all timers 0.
- Reset mid-gate: gate drops the cycle after the reset edge. No result_valid is produced.
- run sampled 1 at edge E:
  - cnt_clear is high in cycle E+1.
  - gate is high in cycles E+2 … E+1+G.
  - SETTLE fills the next S cycles.
  - result_valid is high in cycle E+2+G+S.
- Continuous mode: result_valid period is G+S+2 cycles (LATCH, CLEAR, G, S). cnt_clear follows result_valid by exactly 1 cycle.
- result, result_range and overrange are stable from the LATCH cycle until the next LATCH.
- busy is high from E+1 through the LATCH cycle.

## Test plan
- Params GATE0..3 = 100/50/20/10, SETTLE=2, HI=80, LO=5. The bench counter counts signal edges while gate=1.
- Single shot, manual range 2, 1 edge per 2 clocks: run pulsed 1 cycle → cnt_clear 1 cycle, gate high 20 cycles, result_valid once at E+24 with result=10, result_range=2. Then IDLE, busy=0.
- Continuous, manual range 3: result_valid every 14 cycles, cnt_clear exactly 1 cycle after each strobe.
- Auto-range up, every-cycle edges from range 0: count 100 > 80 → range 1. Next result 50 is kept, range stays 1.
- Auto-range down and saturation:
  - 1 edge per 40 clocks at range 3: count 0 < 5 steps the range down 3→2→1→0, then holds at 0.
  - Forcing cnt_ovf=1 at range 3 gives overrange=1 and the range stays 3.
- run dropped mid-gate → measurement completes, one result_valid, then IDLE. reset_n=0 mid-gate → gate=0 next cycle, no result_valid, all outputs at reset values.
